video_pattern_gen: RTL

VIDEO_PATTERN_GEN -- requirements
Module: video_pattern_gen

---
 rtl/video_pattern_gen.sv | 225 ++++++++++++++++++++++
 1 files changed

// File: rtl/video_pattern_gen.sv
// ---------------------------------------------------------------------------
// video_pattern_gen
// Interlaced luma test-pattern source. Each sample slot takes two clocks,
// and the valid strobe fires on the second clock of every active slot. A
// frame is made of field 0 followed by field 1. Every field begins with its
// own number of vertical-blank lines. The pattern settings are captured once
// per frame, on the edge that enters field 0 line 0 slot 0.
//
// Ports
//   clk          : single clock, rising edge
//   reset        : synchronous, active-high reset
//   enable       : request to stream frames
//   mode[1:0]    : 0 solid, 1 horizontal ramp, 2 checkerboard, 3 single dot
//   level[7:0]   : solid-mode luma value
//   dot_x/dot_y  : dot position in active coordinates (10 bits each)
//   fvh[2:0]     : {field, vertical blank, horizontal blank}
//   dv           : luma sample valid strobe
//   pixel[7:0]   : luma sample (0 whenever dv is low)
//   frame_count  : completed frames, wrapping at 256
//   busy         : high while streaming
// ---------------------------------------------------------------------------
module video_pattern_gen #(
    parameter int H_ACTIVE  = 720,
    parameter int H_BLANK   = 138,
    parameter int V_ACTIVE  = 240,
    parameter int V_BLANK0  = 22,
    parameter int V_BLANK1  = 23,
    parameter int BLK_SHIFT = 3
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       enable,
    input  logic [1:0] mode,
    input  logic [7:0] level,
    input  logic [9:0] dot_x,
    input  logic [9:0] dot_y,
    output logic [2:0] fvh,
    output logic       dv,
    output logic [7:0] pixel,
    output logic [7:0] frame_count,
    output logic       busy
);

    localparam logic [9:0] LP_HA      = 10'(H_ACTIVE);
    localparam logic [9:0] LP_H_LAST  = 10'(H_ACTIVE + H_BLANK - 1);
    localparam logic [9:0] LP_VB0     = 10'(V_BLANK0);
    localparam logic [9:0] LP_VB1     = 10'(V_BLANK1);
    localparam logic [9:0] LP_F0_LAST = 10'(V_BLANK0 + V_ACTIVE - 1);
    localparam logic [9:0] LP_F1_LAST = 10'(V_BLANK1 + V_ACTIVE - 1);

    typedef enum logic [0:0] {
        ST_IDLE = 1'b0,
        ST_RUN  = 1'b1
    } state_t;

    state_t     r_state;
    logic       r_phase;
    logic [9:0] r_slot;
    logic [9:0] r_line;
    logic       r_field;
    logic [1:0] r_mode;
    logic [7:0] r_level;
    logic [9:0] r_dot_x;
    logic [9:0] r_dot_y;
    logic [2:0] r_fvh;
    logic       r_dv;
    logic [7:0] r_pixel;
    logic [7:0] r_frame_count;
    logic       r_busy;

    state_t     w_state_nxt;
    logic       w_phase_nxt;
    logic [9:0] w_slot_nxt;
    logic [9:0] w_line_nxt;
    logic       w_field_nxt;
    logic [7:0] w_fcnt_nxt;
    logic       w_latch;
    logic [9:0] w_line_last;
    logic [9:0] w_vblank_nxt;
    logic       w_h_nxt;
    logic       w_v_nxt;
    logic [9:0] w_y_nxt;
    logic       w_dv_nxt;
    logic [7:0] w_pix_nxt;
    logic [2:0] w_fvh_nxt;

    assign w_line_last = r_field ? LP_F1_LAST : LP_F0_LAST;

    // Next-state and raster-position update for the IDLE/RUN machine.
    always_comb begin
        w_state_nxt = r_state;
        w_phase_nxt = r_phase;
        w_slot_nxt  = r_slot;
        w_line_nxt  = r_line;
        w_field_nxt = r_field;
        w_fcnt_nxt  = r_frame_count;
        w_latch     = 1'b0;
        case (r_state)
            ST_IDLE: begin
                w_phase_nxt = 1'b0;
                w_slot_nxt  = 10'd0;
                w_line_nxt  = 10'd0;
                w_field_nxt = 1'b0;
                if (enable) begin
                    w_state_nxt = ST_RUN;
                    w_latch     = 1'b1;
                end else begin
                    w_state_nxt = ST_IDLE;
                end
            end
            ST_RUN: begin
                if (r_phase == 1'b0) begin
                    w_phase_nxt = 1'b1;
                end else begin
                    w_phase_nxt = 1'b0;
                    if (r_slot != LP_H_LAST) begin
                        w_slot_nxt = r_slot + 10'd1;
                    end else begin
                        w_slot_nxt = 10'd0;
                        if (r_line != w_line_last) begin
                            w_line_nxt = r_line + 10'd1;
                        end else begin
                            w_line_nxt = 10'd0;
                            if (r_field == 1'b0) begin
                                // Field 1 always follows field 0.
                                w_field_nxt = 1'b1;
                            end else begin
                                w_field_nxt = 1'b0;
                                w_fcnt_nxt  = r_frame_count + 8'd1;
                                if (enable) begin
                                    w_latch = 1'b1;
                                end else begin
                                    w_state_nxt = ST_IDLE;
                                end
                            end
                        end
                    end
                end
            end
            default: begin
                w_state_nxt = ST_IDLE;
                w_phase_nxt = 1'b0;
                w_slot_nxt  = 10'd0;
                w_line_nxt  = 10'd0;
                w_field_nxt = 1'b0;
            end
        endcase
    end

    // The outputs are computed from the next raster position, so that the
    // registered outputs match the position held in the counters.
    always_comb begin
        w_vblank_nxt = w_field_nxt ? LP_VB1 : LP_VB0;
        w_h_nxt      = (w_slot_nxt >= LP_HA);
        w_v_nxt      = (w_line_nxt < w_vblank_nxt);
        w_y_nxt      = w_line_nxt - w_vblank_nxt;
        w_dv_nxt     = (w_state_nxt == ST_RUN) && w_phase_nxt && !w_h_nxt && !w_v_nxt;
        if (w_state_nxt == ST_RUN) begin
            w_fvh_nxt = {w_field_nxt, w_v_nxt, w_h_nxt};
        end else begin
            w_fvh_nxt = 3'b011;
        end
    end

    // Pattern generator: this is evaluated only for active samples. As a
    // result, a dot placed outside the active area never matches.
    always_comb begin
        w_pix_nxt = 8'h00;
        if (w_dv_nxt) begin
            case (r_mode)
                2'd0:    w_pix_nxt = r_level;
                2'd1:    w_pix_nxt = w_slot_nxt[7:0];
                2'd2:    w_pix_nxt = (w_slot_nxt[BLK_SHIFT] ^ w_y_nxt[BLK_SHIFT]) ? 8'hFF : 8'h00;
                2'd3:    w_pix_nxt = ((w_slot_nxt == r_dot_x) && (w_y_nxt == r_dot_y)) ? 8'hFF : 8'h00;
                default: w_pix_nxt = 8'h00;
            endcase
        end else begin
            w_pix_nxt = 8'h00;
        end
    end

    // State, counters, per-frame settings and registered outputs.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_state       <= ST_IDLE;
            r_phase       <= 1'b0;
            r_slot        <= 10'd0;
            r_line        <= 10'd0;
            r_field       <= 1'b0;
            r_mode        <= 2'd0;
            r_level       <= 8'h00;
            r_dot_x       <= 10'd0;
            r_dot_y       <= 10'd0;
            r_fvh         <= 3'b011;
            r_dv          <= 1'b0;
            r_pixel       <= 8'h00;
            r_frame_count <= 8'd0;
            r_busy        <= 1'b0;
        end else begin
            r_state       <= w_state_nxt;
            r_phase       <= w_phase_nxt;
            r_slot        <= w_slot_nxt;
            r_line        <= w_line_nxt;
            r_field       <= w_field_nxt;
            r_fvh         <= w_fvh_nxt;
            r_dv          <= w_dv_nxt;
            r_pixel       <= w_pix_nxt;
            r_frame_count <= w_fcnt_nxt;
            r_busy        <= (w_state_nxt == ST_RUN);
            if (w_latch) begin
                r_mode  <= mode;
                r_level <= level;
                r_dot_x <= dot_x;
                r_dot_y <= dot_y;
            end
        end
    end

    assign fvh         = r_fvh;
    assign dv          = r_dv;
    assign pixel       = r_pixel;
    assign frame_count = r_frame_count;
    assign busy        = r_busy;

endmodule
